// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller with IR, decoder, BYPASS and IDCODE DRs
//
// Ports:
//   TCK        test clock, every flop on its rising edge
//   TRST_N     asynchronous active-low TAP reset
//   TMS        mode select, steers the TAP state machine
//   TDI        serial data in
//   TDO        serial data out, LSB of the register currently being shifted
//   TDO_EN     high only in Shift-DR / Shift-IR
//   bsr_tdo    serial output of the last cell of the external boundary chain
//   capturedr  boundary chain capture enable (Capture-DR, BSR selected)
//   shiftdr    boundary chain shift select (Shift-DR, BSR selected)
//   updatedr   boundary chain update enable (Update-DR, BSR selected)
//   mode_test  cells drive their update latch (EXTEST / INTEST)
//   hold_int   core-side hold for INTEST
//   inst       instruction currently in force
//   tap_state  1149.1 state code, for debug

module jtag_tap_ctrl #(
    parameter int              IR_W      = 4,
    parameter logic [31:0]     IDCODE    = 32'h1000_0765,
    parameter logic [IR_W-1:0] OP_EXTEST = 4'h0,
    parameter logic [IR_W-1:0] OP_SAMPLE = 4'h1,
    parameter logic [IR_W-1:0] OP_INTEST = 4'h2,
    parameter logic [IR_W-1:0] OP_IDCODE = 4'h3
) (
    input  logic            TCK,
    input  logic            TRST_N,
    input  logic            TMS,
    input  logic            TDI,
    output logic            TDO,
    output logic            TDO_EN,
    input  logic            bsr_tdo,
    output logic            capturedr,
    output logic            shiftdr,
    output logic            updatedr,
    output logic            mode_test,
    output logic            hold_int,
    output logic [IR_W-1:0] inst,
    output logic [3:0]      tap_state
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_t;

    // Fixed 01 pattern in the two LSBs lets a debugger verify IR chain length.
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    tap_state_t      state;
    tap_state_t      next_state;
    logic [IR_W-1:0] ir_sr;
    logic            bypass_r;
    logic [31:0]     idcode_sr;
    logic            sel_bsr;
    logic            sel_id;

    assign sel_bsr = (inst == OP_EXTEST) || (inst == OP_SAMPLE) || (inst == OP_INTEST);
    assign sel_id  = (inst == OP_IDCODE);

    // State register
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            TLR:     next_state = TMS ? TLR    : RTI;
            RTI:     next_state = TMS ? SEL_DR : RTI;
            SEL_DR:  next_state = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = TMS ? EX1_DR : SH_DR;
            SH_DR:   next_state = TMS ? EX1_DR : SH_DR;
            EX1_DR:  next_state = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = TMS ? UPD_DR : SH_DR;
            UPD_DR:  next_state = TMS ? SEL_DR : RTI;
            SEL_IR:  next_state = TMS ? TLR    : CAP_IR;
            CAP_IR:  next_state = TMS ? EX1_IR : SH_IR;
            SH_IR:   next_state = TMS ? EX1_IR : SH_IR;
            EX1_IR:  next_state = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = TMS ? UPD_IR : SH_IR;
            UPD_IR:  next_state = TMS ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    // Instruction and data registers. Exit/Pause states fall through and hold.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr     <= '0;
            inst      <= OP_IDCODE;
            bypass_r  <= 1'b0;
            idcode_sr <= '0;
        end else begin
            case (state)
                CAP_IR: ir_sr <= IR_CAPTURE;
                SH_IR:  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
                default: ;
            endcase

            // Arriving in Test-Logic-Reset restores IDCODE just like TRST_N.
            if (next_state == TLR) begin
                inst <= OP_IDCODE;
            end else if (state == UPD_IR) begin
                inst <= ir_sr;
            end

            if (sel_id) begin
                if (state == CAP_DR) begin
                    idcode_sr <= IDCODE | 32'h1;
                end else if (state == SH_DR) begin
                    idcode_sr <= {TDI, idcode_sr[31:1]};
                end
            end

            if (!sel_bsr && !sel_id) begin
                if (state == CAP_DR) begin
                    bypass_r <= 1'b0;
                end else if (state == SH_DR) begin
                    bypass_r <= TDI;
                end
            end
        end
    end

    // Outputs decode the registered state only, so TMS cannot glitch them.
    always_comb begin
        TDO_EN    = 1'b0;
        TDO       = 1'b0;
        capturedr = 1'b0;
        shiftdr   = 1'b0;
        updatedr  = 1'b0;
        case (state)
            SH_IR: begin
                TDO_EN = 1'b1;
                TDO    = ir_sr[0];
            end
            SH_DR: begin
                TDO_EN  = 1'b1;
                shiftdr = sel_bsr;
                if (sel_bsr) begin
                    TDO = bsr_tdo;
                end else if (sel_id) begin
                    TDO = idcode_sr[0];
                end else begin
                    TDO = bypass_r;
                end
            end
            CAP_DR:  capturedr = sel_bsr;
            UPD_DR:  updatedr  = sel_bsr;
            default: ;
        endcase
        mode_test = (inst == OP_EXTEST) || (inst == OP_INTEST);
        hold_int  = (inst == OP_INTEST);
        tap_state = state;
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - randomized scoreboard bench for jtag_tap_ctrl

module tb_jtag_tap_ctrl;

    logic       TCK = 1'b0;
    logic       TRST_N = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       bsr_tdo = 1'b0;
    logic       TDO, TDO_EN, capturedr, shiftdr, updatedr, mode_test, hold_int;
    logic [3:0] inst;
    logic [3:0] tap_state;

    jtag_tap_ctrl dut (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TDO_EN    (TDO_EN),
        .bsr_tdo   (bsr_tdo),
        .capturedr (capturedr),
        .shiftdr   (shiftdr),
        .updatedr  (updatedr),
        .mode_test (mode_test),
        .hold_int  (hold_int),
        .inst      (inst),
        .tap_state (tap_state)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic [3:0] st;
        logic [3:0] ins;
        logic       en, cap, sh, upd, mt, hi;
    } stat_t;

    stat_t status_q[$];
    bit    data_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: 1149.1 transition table plus registers as bit queues
    int m_state;
    int m_inst;
    bit m_ir[$];
    bit m_dr[$];
    int nxt[16][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dr_sel(input int ins);
        if (ins == 0 || ins == 1 || ins == 2) return 0;  // boundary chain
        if (ins == 3) return 1;                          // IDCODE
        return 2;                                        // BYPASS
    endfunction

    task automatic set_tr(input int s, input int on0, input int on1);
        nxt[s][0] = on0;
        nxt[s][1] = on1;
    endtask

    task automatic step(input bit tms, input bit tdi, input bit bsr, input bit rstn);
        stat_t       e;
        int          sel;
        logic [31:0] idv;
        @(negedge TCK);
        TMS = tms; TDI = tdi; bsr_tdo = bsr; TRST_N = rstn;
        if (!rstn) begin
            m_state = 15;
            m_inst  = 3;
            m_ir.delete();
            for (int i = 0; i < 4; i++) m_ir.push_back(1'b0);
            m_dr.delete();
        end
        sel   = dr_sel(m_inst);
        e.st  = 4'(m_state);
        e.ins = 4'(m_inst);
        e.en  = (m_state == 2) || (m_state == 10);
        e.cap = (m_state == 6) && (sel == 0);
        e.sh  = (m_state == 2) && (sel == 0);
        e.upd = (m_state == 5) && (sel == 0);
        e.mt  = (m_inst == 0) || (m_inst == 2);
        e.hi  = (m_inst == 2);
        status_q.push_back(e);
        if (!rstn) return;

        if (m_state == 10) begin
            data_q.push_back(m_ir.pop_front());
            m_ir.push_back(tdi);
        end
        if (m_state == 2) begin
            if (sel == 0) begin
                data_q.push_back(bsr);
            end else begin
                data_q.push_back(m_dr.pop_front());
                m_dr.push_back(tdi);
            end
        end
        if (m_state == 14) begin
            m_ir.delete();
            for (int i = 0; i < 4; i++) m_ir.push_back(i == 0);
        end
        if (m_state == 13) begin
            m_inst = 0;
            for (int i = 0; i < 4; i++) m_inst += int'(m_ir[i]) << i;
        end
        if (m_state == 6) begin
            m_dr.delete();
            if (sel == 1) begin
                idv = 32'h1000_0765 | 32'h1;
                for (int i = 0; i < 32; i++) m_dr.push_back(idv[i]);
            end else if (sel == 2) begin
                m_dr.push_back(1'b0);
            end
        end
        m_state = nxt[m_state][tms];
        if (m_state == 15) m_inst = 3;
    endtask

    task automatic t(input bit tms);
        step(tms, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // From Run-Test/Idle: load an instruction, end back in Run-Test/Idle
    task automatic scan_ir(input logic [3:0] val);
        t(1); t(1); t(0); t(0);
        for (int i = 0; i < 4; i++) step(i == 3, val[i], 1'($urandom), 1'b1);
        t(1); t(0);
    endtask

    // From Run-Test/Idle: shift n DR bits, optionally pausing 6 cycles after pause_at bits
    task automatic scan_dr(input logic [63:0] data, input int n, input int pause_at);
        t(1); t(0); t(0);
        for (int i = 0; i < n; i++) begin
            step((i == n - 1) || (i == pause_at - 1), data[i], 1'($urandom), 1'b1);
            if (i == pause_at - 1 && i != n - 1) begin
                t(0);
                repeat (5) t(0);
                t(1); t(0);
            end
        end
        t(1); t(0);
    endtask

    // Monitor: status every cycle, serial data whenever the DUT drives TDO
    initial begin
        stat_t e;
        forever begin
            @(negedge TCK);
            #2;
            if (status_q.size() != 0) begin
                e = status_q.pop_front();
                chk("tap_state", 32'(tap_state), 32'(e.st));
                chk("inst", 32'(inst), 32'(e.ins));
                chk("tdo_en", 32'(TDO_EN), 32'(e.en));
                chk("capturedr", 32'(capturedr), 32'(e.cap));
                chk("shiftdr", 32'(shiftdr), 32'(e.sh));
                chk("updatedr", 32'(updatedr), 32'(e.upd));
                chk("mode_test", 32'(mode_test), 32'(e.mt));
                chk("hold_int", 32'(hold_int), 32'(e.hi));
                if (TDO_EN) begin
                    if (data_q.size() == 0) chk("tdo_unexpected", 32'd1, 32'd0);
                    else chk("tdo", 32'(TDO), 32'(data_q.pop_front()));
                end else begin
                    chk("tdo_idle", 32'(TDO), 32'd0);
                end
            end
        end
    end

    initial begin
        set_tr(15, 12, 15); set_tr(12, 12, 7);  set_tr(7, 6, 4);   set_tr(6, 2, 1);
        set_tr(2, 2, 1);    set_tr(1, 3, 5);    set_tr(3, 3, 0);   set_tr(0, 2, 5);
        set_tr(5, 12, 7);   set_tr(4, 14, 15);  set_tr(14, 10, 9); set_tr(10, 10, 9);
        set_tr(9, 11, 13);  set_tr(11, 11, 8);  set_tr(8, 10, 13); set_tr(13, 12, 7);
        m_state = 15;
        m_inst  = 3;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        t(1); t(1); t(0);

        // IDCODE straight after reset
        scan_dr(64'($urandom), 32, 0);

        // All-ones IR selects BYPASS, then 1,0,1,1 through the bypass bit
        scan_ir(4'hF);
        scan_dr(64'b1101, 4, 0);
        scan_dr(64'($urandom), 9, 0);

        // Boundary-chain instructions
        scan_ir(4'h0);
        scan_dr(64'($urandom), 8, 0);
        scan_ir(4'h1);
        scan_dr(64'($urandom), 5, 0);
        scan_ir(4'h2);
        scan_dr(64'($urandom), 6, 0);

        // IDCODE with Pause-DR after 10 bits
        scan_ir(4'h3);
        scan_dr({32'($urandom), 32'($urandom)}, 32, 10);

        // Five TMS=1 from Shift-DR reach Test-Logic-Reset, inst reverts
        scan_ir(4'h0);
        t(1); t(0); t(0); t(0); t(0);
        repeat (5) t(1);
        t(0);

        // Reset in the middle of Shift-IR
        scan_ir(4'h2);
        t(1); t(1); t(0); t(0); t(0); t(0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        t(0); t(0);

        // Free-running random TMS/TDI with occasional resets
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 63) != 0);
        end
        repeat (6) t(1);
        t(0);

        @(negedge TCK);
        #4;
        chk("data_q_drained", 32'(data_q.size()), 32'd0);
        chk("status_q_drained", 32'(status_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
